// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: encoding patterns, decode result
// types and the fetch tracker state.
package cpu_pkg;

    localparam int PC_WIDTH_DEFAULT = 8;

    // Each opcode is recognised by (ir & MSK) == PAT; reserved bits sit inside the mask.
    localparam logic [7:0] PAT_PAUSE  = 8'h01, MSK_PAUSE  = 8'hFF;
    localparam logic [7:0] PAT_SR0    = 8'h10, MSK_SR0    = 8'hF0;
    localparam logic [7:0] PAT_SRH0   = 8'h20, MSK_SRH0   = 8'hF0;
    localparam logic [7:0] PAT_CLR    = 8'h30, MSK_CLR    = 8'hFC;
    localparam logic [7:0] PAT_BRZ    = 8'h40, MSK_BRZ    = 8'hE0;
    localparam logic [7:0] PAT_BR     = 8'h60, MSK_BR     = 8'hE0;
    localparam logic [7:0] PAT_ADDI   = 8'h80, MSK_ADDI   = 8'hE0;
    localparam logic [7:0] PAT_SUBI   = 8'hA0, MSK_SUBI   = 8'hE0;
    localparam logic [7:0] PAT_MOV    = 8'hC0, MSK_MOV    = 8'hF0;
    localparam logic [7:0] PAT_MOVA   = 8'hD0, MSK_MOVA   = 8'hF3;
    localparam logic [7:0] PAT_MOVR   = 8'hE0, MSK_MOVR   = 8'hF0;
    localparam logic [7:0] PAT_MOVRHS = 8'hF0, MSK_MOVRHS = 8'hF0;

    typedef enum logic [1:0] {
        TRK_IDLE  = 2'd0,
        TRK_WAIT  = 2'd1,
        TRK_VALID = 2'd2
    } trk_state_e;

    typedef struct packed {
        logic br;
        logic brz;
        logic addi;
        logic subi;
        logic sr0;
        logic srh0;
        logic clr;
        logic mov;
        logic mova;
        logic movr;
        logic movrhs;
        logic pause;
        logic illegal;
    } op_strobes_t;

    typedef struct packed {
        logic [4:0] imm5;
        logic [1:0] reg_a;
        logic [1:0] reg_b;
    } dec_fields_t;

    function automatic logic match_enc(input logic [7:0] ir, input logic [7:0] pat,
                                       input logic [7:0] msk);
        return (ir & msk) == pat;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decode: IR byte to one-hot opcode strobes
// plus immediate/register fields. The parent registers the results.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0]  ir_i,
    output op_strobes_t strobes_o,
    output dec_fields_t fields_o
);

    always_comb begin
        strobes_o        = '0;
        strobes_o.br     = match_enc(ir_i, PAT_BR,     MSK_BR);
        strobes_o.brz    = match_enc(ir_i, PAT_BRZ,    MSK_BRZ);
        strobes_o.addi   = match_enc(ir_i, PAT_ADDI,   MSK_ADDI);
        strobes_o.subi   = match_enc(ir_i, PAT_SUBI,   MSK_SUBI);
        strobes_o.sr0    = match_enc(ir_i, PAT_SR0,    MSK_SR0);
        strobes_o.srh0   = match_enc(ir_i, PAT_SRH0,   MSK_SRH0);
        strobes_o.clr    = match_enc(ir_i, PAT_CLR,    MSK_CLR);
        strobes_o.mov    = match_enc(ir_i, PAT_MOV,    MSK_MOV);
        strobes_o.mova   = match_enc(ir_i, PAT_MOVA,   MSK_MOVA);
        strobes_o.movr   = match_enc(ir_i, PAT_MOVR,   MSK_MOVR);
        strobes_o.movrhs = match_enc(ir_i, PAT_MOVRHS, MSK_MOVRHS);
        strobes_o.pause  = match_enc(ir_i, PAT_PAUSE,  MSK_PAUSE);
        // The patterns are disjoint, so anything matching none is unassigned.
        strobes_o.illegal = ~(|strobes_o[12:1]);

        fields_o       = '0;
        fields_o.imm5  = ir_i[4:0];
        fields_o.reg_a = (strobes_o.addi || strobes_o.subi) ? ir_i[4:3] : ir_i[3:2];
        fields_o.reg_b = ir_i[1:0];
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// CPU front end: program counter, ROM fetch tracking, instruction register and
// registered decode outputs for the control FSM.
module fetch_decode_unit
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int ROM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fetch,
    input  logic                increment_pc,
    input  logic                commit_branch,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [7:0]          imem_data,
    output logic                instr_valid,
    output logic                br,
    output logic                brz,
    output logic                addi,
    output logic                subi,
    output logic                sr0,
    output logic                srh0,
    output logic                clr,
    output logic                mov,
    output logic                mova,
    output logic                movr,
    output logic                movrhs,
    output logic                pause,
    output logic                illegal,
    output logic [2:0]          imm3,
    output logic [3:0]          imm4,
    output logic [4:0]          imm5,
    output logic [1:0]          reg_a,
    output logic [1:0]          reg_b,
    output logic [PC_WIDTH-1:0] pc,
    output trk_state_e          dbg_state
);

    localparam logic [1:0] LAST_WAIT = 2'(ROM_LATENCY);

    trk_state_e          state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                load;
    logic [PC_WIDTH-1:0] pc_q, pc_d, addr_q;
    logic [7:0]          ir_q, ir_d;
    op_strobes_t         dec_strobes, strobes_q, strobes_d;
    dec_fields_t         dec_fields, fields_q;

    // WAIT counts edges since the fetch; IR captures imem_data on the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            TRK_IDLE, TRK_VALID: begin
                if (fetch) begin
                    state_d = TRK_WAIT;
                    cnt_d   = '0;
                end
            end
            TRK_WAIT: begin
                if (cnt_q == LAST_WAIT) begin
                    state_d = TRK_VALID;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = TRK_IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (commit_branch) begin
            pc_d = branch_target;
        end else if (increment_pc) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end

    // Decode the value IR is about to hold so strobes line up with instr_valid.
    assign ir_d      = load ? imem_data : ir_q;
    assign strobes_d = (state_d == TRK_VALID) ? dec_strobes : '0;

    instr_decoder u_decoder (
        .ir_i      (ir_d),
        .strobes_o (dec_strobes),
        .fields_o  (dec_fields)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= TRK_IDLE;
            cnt_q     <= '0;
            pc_q      <= '0;
            addr_q    <= '0;
            ir_q      <= '0;
            strobes_q <= '0;
            fields_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            addr_q    <= pc_q;
            ir_q      <= ir_d;
            strobes_q <= strobes_d;
            fields_q  <= dec_fields;
        end
    end

    assign imem_addr   = addr_q;
    assign pc          = pc_q;
    assign instr_valid = (state_q == TRK_VALID);
    assign dbg_state   = state_q;
    assign {br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause, illegal} = strobes_q;
    assign imm5  = fields_q.imm5;
    assign imm4  = fields_q.imm5[3:0];
    assign imm3  = fields_q.imm5[2:0];
    assign reg_a = fields_q.reg_a;
    assign reg_b = fields_q.reg_b;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: two instances (ROM latency 1 and 2) share stimulus
// and are checked against a behavioural model through expected-response queues.
module tb_fetch_decode_unit;

    localparam int LAT1 = 1;
    localparam int LAT2 = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       fetch, increment_pc, commit_branch;
    logic [7:0] branch_target;
    logic [7:0] rom [256];

    logic [7:0]  imem_addr1, imem_addr2, imem_data1, imem_data2, rom_pipe2;
    logic [7:0]  pc1, pc2;
    logic        valid1, valid2;
    logic [12:0] stb1, stb2;
    logic [2:0]  imm3_1, imm3_2;
    logic [3:0]  imm4_1, imm4_2;
    logic [4:0]  imm5_1, imm5_2;
    logic [1:0]  rega1, rega2, regb1, regb2;
    cpu_pkg::trk_state_e st1, st2;
    logic [28:0] obs1, obs2;

    // Reference model state
    logic [28:0] exp_q1[$];
    logic [28:0] exp_q2[$];
    logic [7:0]  pc_m = 8'h00;
    logic [7:0]  addr_m = 8'h00;
    int          wait_left [2] = '{0, 0};
    logic        valid_m [2] = '{1'b0, 1'b0};
    logic        vprev [2] = '{1'b0, 1'b0};
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fetch_decode_unit #(.PC_WIDTH(8), .ROM_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .fetch(fetch), .increment_pc(increment_pc),
        .commit_branch(commit_branch), .branch_target(branch_target),
        .imem_addr(imem_addr1), .imem_data(imem_data1), .instr_valid(valid1),
        .br(stb1[12]), .brz(stb1[11]), .addi(stb1[10]), .subi(stb1[9]), .sr0(stb1[8]),
        .srh0(stb1[7]), .clr(stb1[6]), .mov(stb1[5]), .mova(stb1[4]), .movr(stb1[3]),
        .movrhs(stb1[2]), .pause(stb1[1]), .illegal(stb1[0]),
        .imm3(imm3_1), .imm4(imm4_1), .imm5(imm5_1), .reg_a(rega1), .reg_b(regb1),
        .pc(pc1), .dbg_state(st1)
    );

    fetch_decode_unit #(.PC_WIDTH(8), .ROM_LATENCY(LAT2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .fetch(fetch), .increment_pc(increment_pc),
        .commit_branch(commit_branch), .branch_target(branch_target),
        .imem_addr(imem_addr2), .imem_data(imem_data2), .instr_valid(valid2),
        .br(stb2[12]), .brz(stb2[11]), .addi(stb2[10]), .subi(stb2[9]), .sr0(stb2[8]),
        .srh0(stb2[7]), .clr(stb2[6]), .mov(stb2[5]), .mova(stb2[4]), .movr(stb2[3]),
        .movrhs(stb2[2]), .pause(stb2[1]), .illegal(stb2[0]),
        .imm3(imm3_2), .imm4(imm4_2), .imm5(imm5_2), .reg_a(rega2), .reg_b(regb2),
        .pc(pc2), .dbg_state(st2)
    );

    // Synchronous ROMs with one and two cycles of read latency
    always @(posedge clk) imem_data1 <= rom[imem_addr1];
    always @(posedge clk) begin
        rom_pipe2  <= rom[imem_addr2];
        imem_data2 <= rom_pipe2;
    end

    assign obs1 = {stb1, imm5_1, imm4_1, imm3_1, rega1, regb1};
    assign obs2 = {stb2, imm5_2, imm4_2, imm3_2, rega2, regb2};

    // Expected decode from the encoding table: {13 strobes, imm5, imm4, imm3, reg_a, reg_b}
    function automatic logic [28:0] ref_decode(input logic [7:0] b);
        int v, hi, lo, op;
        logic [12:0] s;
        logic [1:0]  ra;
        v  = int'(b);
        hi = v / 16;
        lo = v % 16;
        if (v == 1)                    op = 11;
        else if (hi == 1)              op = 4;
        else if (hi == 2)              op = 5;
        else if (hi == 3 && lo < 4)    op = 6;
        else if (v >= 64 && v < 96)    op = 1;
        else if (v >= 96 && v < 128)   op = 0;
        else if (v >= 128 && v < 160)  op = 2;
        else if (v >= 160 && v < 192)  op = 3;
        else if (hi == 12)             op = 7;
        else if (hi == 13 && lo % 4 == 0) op = 8;
        else if (hi == 14)             op = 9;
        else if (hi == 15)             op = 10;
        else                           op = 12;
        s  = 13'd1 << (12 - op);
        ra = (op == 2 || op == 3) ? 2'((v / 8) % 4) : 2'((v / 4) % 4);
        return {s, 5'(v % 32), 4'(v % 16), 3'(v % 8), ra, 2'(v % 4)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model advances with the same edge.
    task automatic step(input logic f, input logic inc, input logic cb, input logic [7:0] tgt);
        int lat;
        fetch = f;
        increment_pc = inc;
        commit_branch = cb;
        branch_target = tgt;
        @(posedge clk);
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                lat = (k == 0) ? LAT1 : LAT2;
                if (wait_left[k] > 0) begin
                    wait_left[k]--;
                    if (wait_left[k] == 0) valid_m[k] = 1'b1;
                end else if (f) begin
                    if (k == 0) exp_q1.push_back(ref_decode(rom[pc_m]));
                    else        exp_q2.push_back(ref_decode(rom[pc_m]));
                    wait_left[k] = lat + 1;
                    valid_m[k] = 1'b0;
                end
            end
            addr_m = pc_m;
            if (cb)       pc_m = tgt;
            else if (inc) pc_m = pc_m + 8'd1;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        pc_m = 8'h00;
        addr_m = 8'h00;
        wait_left = '{0, 0};
        valid_m = '{1'b0, 1'b0};
        exp_q1.delete();
        exp_q2.delete();
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic mon(input int k, input logic v, input logic [28:0] obs,
                       input logic [7:0] pcv, input logic [7:0] addrv);
        string tag;
        logic [28:0] e;
        tag = (k == 0) ? "L1" : "L2";
        if (!reset_n) begin
            check({tag, "_reset_state"}, 64'({v, obs, pcv, addrv}), 64'd0);
            vprev[k] = 1'b0;
        end else begin
            check({tag, "_pc"}, 64'(pcv), 64'(pc_m));
            check({tag, "_imem_addr"}, 64'(addrv), 64'(addr_m));
            check({tag, "_instr_valid"}, 64'(v), 64'(valid_m[k]));
            if (v) check({tag, "_onehot"}, 64'($countones(obs[28:16])), 64'd1);
            else   check({tag, "_strobes_off"}, 64'(obs[28:16]), 64'd0);
            if (v && !vprev[k]) begin
                if ((k == 0 && exp_q1.size() == 0) || (k == 1 && exp_q2.size() == 0)) begin
                    check({tag, "_unexpected_valid"}, 64'd1, 64'd0);
                end else begin
                    e = (k == 0) ? exp_q1.pop_front() : exp_q2.pop_front();
                    check({tag, "_decode"}, 64'(obs), 64'(e));
                end
            end
            vprev[k] = v;
        end
    endtask

    always @(negedge clk) begin
        mon(0, valid1, obs1, pc1, imem_addr1);
        mon(1, valid2, obs2, pc2, imem_addr2);
    end

    initial begin
        reset_n = 1'b1;
        fetch = 1'b0;
        increment_pc = 1'b0;
        commit_branch = 1'b0;
        branch_target = 8'h00;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        #2;
        do_reset(3);

        // ADDI r1,#3 from address 0
        rom[0] = 8'h8B;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        idle(4);

        // Reset while waiting on the ROM: no stale load, then a clean refetch
        step(1'b1, 1'b0, 1'b0, 8'h00);
        idle(1);
        do_reset(3);
        idle(5);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        idle(4);

        // Branch wins over increment in the same cycle
        rom[5] = 8'h7C;
        step(1'b0, 1'b0, 1'b1, 8'h05);
        step(1'b1, 1'b1, 1'b1, 8'h01);
        idle(4);

        // PC wraps from 0xFF to 0x00
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        idle(2);

        // Fetch held high through WAIT
        rom[0] = 8'hD4;
        step(1'b0, 1'b0, 1'b1, 8'h00);
        repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00);
        idle(5);

        // Every encoding once
        for (int i = 0; i < 256; i++) rom[i] = 8'(i);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            idle(2);
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end

        // Random program, random control traffic
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)));
        end
        idle(8);
        check("L1_drain", 64'(exp_q1.size()), 64'd0);
        check("L2_drain", 64'(exp_q2.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
